// File: rtl/p_det_lookup_pkg.sv
// Shared types and constants for the p_det parameter tables.
// The 30 entries are the irreducible degree-8 polynomials over GF(2), in ascending order.
package p_det_lookup_pkg;

  typedef logic [4:0] p_det_t;
  typedef logic [0:8] base_poly_t;  // bit i = coefficient of x^i

  localparam p_det_t P_DET_MIN = 5'd1;
  localparam p_det_t P_DET_MAX = 5'd30;
  localparam int     D_DEFAULT = 2;

  // Hex form: bit i of the 9-bit value is the coefficient of x^i.
  localparam logic [8:0] POLY_TABLE [1:30] = '{
    9'h11B, 9'h11D, 9'h12B, 9'h12D, 9'h139, 9'h13F, 9'h14D, 9'h15F,
    9'h163, 9'h165, 9'h169, 9'h171, 9'h177, 9'h17B, 9'h187, 9'h18B,
    9'h18D, 9'h19F, 9'h1A3, 9'h1A9, 9'h1B1, 9'h1BD, 9'h1C3, 9'h1CF,
    9'h1D7, 9'h1DD, 9'h1E7, 9'h1F3, 9'h1F5, 9'h1F9
  };

  // Maps the hex form onto the ascending-index base_poly_t layout.
  function automatic base_poly_t to_base_poly(input logic [8:0] hex);
    base_poly_t p;
    for (int i = 0; i < 9; i++) p[i] = hex[i];
    return p;
  endfunction

endpackage

// File: rtl/params_if.sv
// Parameter-set bundle produced by p_param_extractor.
interface params_if;
  import p_det_lookup_pkg::*;

  base_poly_t P;
  logic [3:0] red_deg;

  modport ext_p (output P, red_deg);
  modport use_p (input P, red_deg);
endinterface

// File: rtl/p_param_extractor.sv
// Combinational table lookup: p_det index -> parameter set.
module p_param_extractor
  import p_det_lookup_pkg::*;
#(
  parameter int d = D_DEFAULT
) (
  input  p_det_t      p_det,
  params_if.ext_p     ext
);

  // NOTE: default assignment first in always_comb so no path leaves P unassigned (no latch).
  always_comb begin
    ext.P = 'x;
    if (p_det >= P_DET_MIN && p_det <= P_DET_MAX) ext.P = to_base_poly(POLY_TABLE[p_det]);
  end

  assign ext.red_deg = 4'(d);

endmodule

// File: rtl/p_det_lookup.sv
// Reverse lookup P -> p_det by scanning the extractor one index per clock.
module p_det_lookup
  import p_det_lookup_pkg::*;
#(
  parameter int d = D_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  base_poly_t req_P,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output p_det_t     rsp_p_det,
  output logic       rsp_found
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t     state;
  p_det_t     idx;
  base_poly_t p_reg;
  logic       match;

  params_if ext_if ();

  p_param_extractor #(.d(d)) u_ext (
    .p_det (idx),
    .ext   (ext_if.ext_p)
  );

  assign match     = (ext_if.P == p_reg);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= P_DET_MIN;
      p_reg     <= '0;
      rsp_p_det <= '0;
      rsp_found <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          p_reg <= req_P;
          idx   <= P_DET_MIN;
          // Not monic degree 8, or divisible by x: cannot be in the table.
          if (!req_P[8] || !req_P[0]) begin
            rsp_p_det <= '0;
            rsp_found <= 1'b0;
            state     <= RESP;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            rsp_p_det <= idx;
            rsp_found <= 1'b1;
            state     <= RESP;
          end else if (idx == P_DET_MAX) begin
            rsp_p_det <= '0;
            rsp_found <= 1'b0;
            state     <= RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    (state == SCAN) |-> (idx >= P_DET_MIN && idx <= P_DET_MAX));

endmodule

// File: tb/tb_p_det_lookup.sv
// Directed bench for p_det_lookup: hits, misses, rejects, backpressure, reset abort.
module tb_p_det_lookup;
  import p_det_lookup_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  base_poly_t req_P;
  logic       rsp_valid;
  logic       rsp_ready;
  p_det_t     rsp_p_det;
  logic       rsp_found;

  int checks = 0;
  int errors = 0;

  // Independent copy of the irreducible degree-8 polynomial list (bit i = x^i).
  logic [8:0] tbl [1:30] = '{
    9'h11B, 9'h11D, 9'h12B, 9'h12D, 9'h139, 9'h13F, 9'h14D, 9'h15F,
    9'h163, 9'h165, 9'h169, 9'h171, 9'h177, 9'h17B, 9'h187, 9'h18B,
    9'h18D, 9'h19F, 9'h1A3, 9'h1A9, 9'h1B1, 9'h1BD, 9'h1C3, 9'h1CF,
    9'h1D7, 9'h1DD, 9'h1E7, 9'h1F3, 9'h1F5, 9'h1F9
  };

  p_det_lookup dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_P     (req_P),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p_det (rsp_p_det),
    .rsp_found (rsp_found)
  );

  always #5 clk = ~clk;

  function automatic base_poly_t to_poly(input logic [8:0] hex);
    base_poly_t p;
    for (int i = 0; i < 9; i++) p[i] = hex[i];
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction; hold = cycles of rsp_ready=0 in RESP, tie = rsp_ready held high.
  task automatic run_req(input string tag, input logic [8:0] hex, input int exp_pdet,
                         input bit exp_found, input int exp_lat, input bit toggle,
                         input bit tie, input int hold);
    int lat;
    bit ready_low;
    bit stable;
    rsp_ready = tie;
    @(negedge clk);
    req_P     = to_poly(hex);
    req_valid = 1'b1;
    check({tag, "_ready_in"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat       = 1;
    ready_low = 1'b1;
    while (!rsp_valid && lat < 40) begin
      if (req_ready) ready_low = 1'b0;
      if (toggle) req_P = ~req_P;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"},     32'(rsp_valid), 32'd1);
    check({tag, "_latency"},   32'(lat),       32'(exp_lat));
    check({tag, "_p_det"},     32'(rsp_p_det), 32'(exp_pdet));
    check({tag, "_found"},     32'(rsp_found), 32'(exp_found));
    check({tag, "_ready_low"}, 32'(ready_low), 32'd1);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (rsp_valid !== 1'b1 || rsp_p_det !== p_det_t'(exp_pdet) ||
            rsp_found !== exp_found || req_ready !== 1'b0) stable = 1'b0;
      end
      check({tag, "_hold_stable"}, 32'(stable), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = tie;
    check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit quiet;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_P     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_p_det", 32'(rsp_p_det), 32'd0);
    check("reset_found", 32'(rsp_found), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", 32'(req_ready), 32'd1);

    // Single hit at index 7.
    run_req("p7", tbl[7], 7, 1'b1, 8, 1'b0, 1'b0, 0);

    // Sweep every table entry.
    for (int k = 1; k <= 30; k++)
      run_req($sformatf("sweep%0d", k), tbl[k], k, 1'b1, k + 1, 1'b0, 1'b0, 0);

    // Miss (x^8+1) and pre-check rejects.
    run_req("miss",     9'h101, 0, 1'b0, 31, 1'b0, 1'b0, 0);
    run_req("deg_low",  9'h081, 0, 1'b0, 1,  1'b0, 1'b0, 0);
    run_req("div_by_x", 9'h11A, 0, 1'b0, 1,  1'b0, 1'b0, 0);

    // Backpressure, then an immediately following request.
    run_req("bp",       tbl[12], 12, 1'b1, 13, 1'b0, 1'b0, 5);
    run_req("after_bp", tbl[2],  2,  1'b1, 3,  1'b0, 1'b0, 0);

    // Reset 10 cycles into a miss scan.
    @(negedge clk);
    req_P     = to_poly(9'h101);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_p_det", 32'(rsp_p_det), 32'd0);
    check("abort_found", 32'(rsp_found), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst   = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) quiet = 1'b0;
    end
    check("abort_no_rsp", 32'(quiet), 32'd1);
    run_req("after_abort", tbl[3], 3, 1'b1, 4, 1'b0, 1'b0, 0);

    // Back-to-back with rsp_ready tied high and req_P toggling mid-scan.
    run_req("b2b_a", tbl[5],  5,  1'b1, 6,  1'b1, 1'b1, 0);
    run_req("b2b_b", tbl[20], 20, 1'b1, 21, 1'b1, 1'b1, 0);
    run_req("b2b_c", 9'h101,  0,  1'b0, 31, 1'b1, 1'b1, 0);
    run_req("b2b_d", tbl[30], 30, 1'b1, 31, 1'b1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
